// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_io_pkg
// Description : Shared constants and counter-width helper for the board-I/O
//               front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package board_io_pkg;

   localparam int IO_BUS_W = 32;

   // Width of a counter that must hold values 0..n-1.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_io_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : board_io_conditioner_if
// Description : Pin-side inputs and core-side outputs of the board-I/O
//               conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface board_io_conditioner_if #(
   parameter int N_SW    = 10,
   parameter int N_KEY   = 4,
   parameter int N_PULSE = 1
);
   import board_io_pkg::*;

   logic [N_SW-1:0]     i_sw;
   logic [N_KEY-1:0]    i_key_n;
   logic [N_PULSE-1:0]  i_pulse;
   logic [N_SW-1:0]     o_sw;
   logic [N_KEY-1:0]    o_key;
   logic [N_KEY-1:0]    o_key_press;
   logic [N_KEY-1:0]    o_key_release;
   logic [IO_BUS_W-1:0] o_io_sw;
   logic [N_PULSE-1:0]  o_led_stretch;

   modport master (
      output i_sw, i_key_n, i_pulse,
      input  o_sw, o_key, o_key_press, o_key_release, o_io_sw, o_led_stretch
   );

   modport slave (
      input  i_sw, i_key_n, i_pulse,
      output o_sw, o_key, o_key_press, o_key_release, o_io_sw, o_led_stretch
   );

endinterface
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce
// Description : One input channel: synchroniser, debounce counter and
//               registered rise/fall strobes. Output is active-high.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   import board_io_pkg::*;

   localparam int               c_cnt_w = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [c_cnt_w-1:0]     r_cnt;
   logic                   r_stable;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_level;

   // The inactive pin level maps to 0, so active-low keys come out active-high.
   assign w_level = r_sync[SYNC_STAGES-1] ^ RESET_LEVEL;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= {SYNC_STAGES{RESET_LEVEL}};
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_level == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == c_term) begin
            r_stable <= w_level;
            r_cnt    <= '0;
            r_rise   <= w_level;
            r_fall   <= ~w_level;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_stable;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/board_io_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : board_io_conditioner
// Description : Debounces switches and keys, generates key strobes, packs the
//               core switch bus and stretches core pulses for LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module board_io_conditioner #(
   parameter int N_SW            = 10,
   parameter int N_KEY           = 4,
   parameter int N_PULSE         = 1,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int STRETCH_CYCLES  = 2500000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   board_io_conditioner_if.slave  bus
);
   import board_io_pkg::*;

   localparam int                 c_str_w    = $clog2(STRETCH_CYCLES + 1);
   localparam logic [c_str_w-1:0] c_str_load = c_str_w'(STRETCH_CYCLES);

   if (N_SW + N_KEY > IO_BUS_W) begin : g_chk_bus_width
      $error("board_io_conditioner: N_SW + N_KEY exceeds core switch bus width");
   end
   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_chk_params
      $error("board_io_conditioner: illegal SYNC/DEBOUNCE/STRETCH parameter");
   end

   logic [N_SW-1:0]     w_sw;
   logic [N_SW-1:0]     w_unused_sw_rise;
   logic [N_SW-1:0]     w_unused_sw_fall;
   logic [N_KEY-1:0]    w_key;
   logic [N_KEY-1:0]    w_key_rise;
   logic [N_KEY-1:0]    w_key_fall;
   logic [N_PULSE-1:0]  w_led;
   logic [IO_BUS_W-1:0] w_io_sw;

   for (genvar g = 0; g < N_SW; g++) begin : g_sw
      io_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0)
      ) u_deb (
         .clk     (i_clk),
         .rst     (i_reset),
         .i_raw   (bus.i_sw[g]),
         .o_level (w_sw[g]),
         .o_rise  (w_unused_sw_rise[g]),
         .o_fall  (w_unused_sw_fall[g])
      );
   end

   for (genvar g = 0; g < N_KEY; g++) begin : g_key
      io_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b1)
      ) u_deb (
         .clk     (i_clk),
         .rst     (i_reset),
         .i_raw   (bus.i_key_n[g]),
         .o_level (w_key[g]),
         .o_rise  (w_key_rise[g]),
         .o_fall  (w_key_fall[g])
      );
   end

   // A trigger reloads the full count even while already stretching.
   for (genvar g = 0; g < N_PULSE; g++) begin : g_stretch
      logic [c_str_w-1:0] r_cnt;

      always_ff @(posedge i_clk or posedge i_reset) begin
         if (i_reset) begin
            r_cnt <= '0;
         end else if (bus.i_pulse[g]) begin
            r_cnt <= c_str_load;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end

      assign w_led[g] = (r_cnt != '0);
   end

   always_comb begin
      w_io_sw              = '0;
      w_io_sw[N_SW-1:0]    = w_sw;
      w_io_sw[N_SW+:N_KEY] = w_key;
   end

   assign bus.o_sw          = w_sw;
   assign bus.o_key         = w_key;
   assign bus.o_key_press   = w_key_rise;
   assign bus.o_key_release = w_key_fall;
   assign bus.o_io_sw       = w_io_sw;
   assign bus.o_led_stretch = w_led;

endmodule
`default_nettype wire

// File: tb/tb_board_io_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_conditioner
// Description : Directed scoreboard bench for board_io_conditioner
//               (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_conditioner;

   typedef struct {
      logic [31:0] io;
      logic [3:0]  press;
      logic [3:0]  rel;
      logic        led;
   } exp_t;

   logic clk;
   logic i_reset;
   int   cyc;
   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];

   board_io_conditioner_if #(.N_SW(10), .N_KEY(4), .N_PULSE(1)) bus ();

   board_io_conditioner #(
      .N_SW            (10),
      .N_KEY           (4),
      .N_PULSE         (1),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .STRETCH_CYCLES  (8)
   ) dut (
      .i_clk   (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [31:0] io, input logic [3:0] pr,
                               input logic [3:0] rl, input logic led);
      exp_t e;
      e.io = io; e.press = pr; e.rel = rl; e.led = led;
      return e;
   endfunction

   // Push the expectation for the edge just taken, then drive the inputs
   // that the next edge samples.
   task automatic step(input exp_t e, input bit do_chk, input logic [9:0] sw,
                       input logic [3:0] kn, input logic p, input logic r);
      @(posedge clk);
      #1;
      if (do_chk) exp_q.push_back(e);
      i_reset     = r;
      bus.i_sw    = sw;
      bus.i_key_n = kn;
      bus.i_pulse = p;
   endtask

   task automatic reset_pulse();
      step(mk(32'h0, 4'h0, 4'h0, 1'b0), 1'b0, 10'h0, 4'hF, 1'b0, 1'b1);
      step(mk(32'h0, 4'h0, 4'h0, 1'b0), 1'b1, 10'h0, 4'hF, 1'b0, 1'b0);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, req);
      end
   endtask

   // Monitor: compares the DUT outputs away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("io_sw",       bus.o_io_sw,                  e.io);
            cmp("sw",          32'(bus.o_sw),                32'(e.io[9:0]));
            cmp("key",         32'(bus.o_key),               32'(e.io[13:10]));
            cmp("key_press",   32'(bus.o_key_press),         32'(e.press));
            cmp("key_release", 32'(bus.o_key_release),       32'(e.rel));
            cmp("led_stretch", 32'(bus.o_led_stretch),       32'(e.led));
         end
      end
   end

   initial begin
      cyc         = 0;
      n_checks    = 0;
      n_errors    = 0;
      i_reset     = 1'b1;
      bus.i_sw    = '0;
      bus.i_key_n = 4'hF;
      bus.i_pulse = '0;

      // Reset state, then idle after release.
      for (int j = 0; j < 4; j++)
         step(mk(32'h0, 4'h0, 4'h0, 1'b0), 1'b1, 10'h0, 4'hF, 1'b0, 1'b1);
      for (int j = 0; j < 21; j++)
         step(mk(32'h0, 4'h0, 4'h0, 1'b0), 1'b1, 10'h0, 4'hF, 1'b0, 1'b0);

      // Switch 3 rises: visible exactly 6 edges later.
      for (int j = 0; j < 12; j++)
         step(mk((j >= 6) ? 32'h8 : 32'h0, 4'h0, 4'h0, 1'b0), 1'b1, 10'h008, 4'hF, 1'b0, 1'b0);
      reset_pulse();

      // Three-cycle glitch on switch 5 is rejected.
      for (int j = 0; j < 33; j++)
         step(mk(32'h0, 4'h0, 4'h0, 1'b0), 1'b1, (j < 3) ? 10'h020 : 10'h000, 4'hF, 1'b0, 1'b0);
      // A real change afterwards still needs the full latency.
      for (int j = 0; j < 10; j++)
         step(mk((j >= 6) ? 32'h20 : 32'h0, 4'h0, 4'h0, 1'b0), 1'b1, 10'h020, 4'hF, 1'b0, 1'b0);
      reset_pulse();

      // Key 0 press and release with single strobes.
      for (int j = 0; j < 10; j++)
         step(mk((j >= 6) ? 32'h400 : 32'h0, (j == 6) ? 4'h1 : 4'h0, 4'h0, 1'b0),
              1'b1, 10'h0, 4'hE, 1'b0, 1'b0);
      for (int j = 0; j < 10; j++)
         step(mk((j >= 6) ? 32'h0 : 32'h400, 4'h0, (j == 6) ? 4'h1 : 4'h0, 1'b0),
              1'b1, 10'h0, 4'hF, 1'b0, 1'b0);
      reset_pulse();

      // Single trigger: 8 high cycles after the sampling edge.
      for (int j = 0; j < 12; j++)
         step(mk(32'h0, 4'h0, 4'h0, (j >= 1 && j <= 8)), 1'b1, 10'h0, 4'hF, (j == 0), 1'b0);
      // Retrigger 5 edges in reloads the full count.
      for (int j = 0; j < 16; j++)
         step(mk(32'h0, 4'h0, 4'h0, (j >= 1 && j <= 13)), 1'b1, 10'h0, 4'hF,
              (j == 0 || j == 5), 1'b0);
      reset_pulse();

      // Reset mid-debounce and mid-stretch; full latency restarts after release.
      for (int j = 0; j < 16; j++)
         step(mk((j >= 10) ? 32'h2 : 32'h0, 4'h0, 4'h0, (j == 1 || j == 2)), 1'b1,
              10'h002, 4'hF, (j == 0), (j == 3));

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
